// File: rtl/gray_cnt.sv
// Binary/Gray counter with registered Gray, binary and wrap outputs for CDC pointer use.
// Optional down-counting selected by defining GRAY_CNT_DOWN_EN (adds the dir port).
module gray_cnt #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [SIZE-1:0] load_bin,
`ifdef GRAY_CNT_DOWN_EN
    input  logic            dir,
`endif
    output logic [SIZE-1:0] bin,
    output logic [SIZE-1:0] gray,
    output logic            wrap
);

    logic [SIZE-1:0] r_bin;
    logic [SIZE-1:0] r_gray;
    logic            r_wrap;

    logic [SIZE-1:0] w_bin_nxt;
    logic [SIZE-1:0] w_gray_nxt;
    logic            w_wrap_nxt;
    logic            w_down;

`ifdef GRAY_CNT_DOWN_EN
    assign w_down = dir;
`else
    assign w_down = 1'b0;
`endif

    // Gray is encoded from the next binary value so both registers update on the same edge.
    always_comb begin
        w_bin_nxt  = r_bin;
        w_wrap_nxt = 1'b0;
        if (load) begin
            w_bin_nxt = load_bin;
        end else if (en) begin
            if (w_down) begin
                w_bin_nxt  = r_bin - SIZE'(1);
                w_wrap_nxt = ~|r_bin;
            end else begin
                w_bin_nxt  = r_bin + SIZE'(1);
                w_wrap_nxt = &r_bin;
            end
        end
        w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;
    assign wrap = r_wrap;

endmodule
